// File: rtl/data_ram_responder_pkg.sv
// Shared widths, FSM state encoding and address helpers for the MEM-stage RAM responder.
package data_ram_responder_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_BUS_W = 32;
  localparam int MEM_SEL_W  = 4;
  localparam int RAM_WAIT_W = 4;

  typedef enum logic [1:0] {
    RAM_ST_IDLE = 2'd0,
    RAM_ST_BUSY = 2'd1,
    RAM_ST_DONE = 2'd2
  } ram_state_e;

  // Any address bit above the word index makes the access miss the RAM.
  function automatic logic addr_out_of_range(input logic [ADDR_BUS_W-1:0] addr,
                                             input int unsigned addr_width);
    return (addr >> (addr_width + 2)) != '0;
  endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data RAM responder (slave).
interface data_ram_if;
  import data_ram_responder_pkg::*;

  logic                  ram_en;
  logic [MEM_SEL_W-1:0]  ram_write_en;
  logic [ADDR_BUS_W-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_write_data;
  logic [DATA_W-1:0]     ram_read_data;
  logic                  ram_ready;
  logic                  stall_req;
  logic                  ram_range_err;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_read_data, ram_ready, stall_req, ram_range_err
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_read_data, ram_ready, stall_req, ram_range_err
  );

endinterface

// File: rtl/data_ram_responder_byte_lane_ram.sv
// Word-organised RAM built from four byte lanes: per-lane synchronous write, gated synchronous read.
module byte_lane_ram
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [MEM_SEL_W-1:0]  we,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [MEM_SEL_W-1:0][7:0] mem [DEPTH];

  // Read register only loads on rd_en so the last read result stays put between reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_SEL_W; i++) begin
      if (we[i]) mem[addr][i] <= wdata[8*i +: 8];
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage RAM responder: latches one request, waits WAIT_STATES cycles, commits it and pulses ready.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic clk,
  input  logic rst,
  data_ram_if.slave bus
);

  localparam logic [RAM_WAIT_W-1:0] WAIT_INIT = RAM_WAIT_W'(WAIT_STATES);
  localparam logic [RAM_WAIT_W-1:0] WAIT_ONE  = RAM_WAIT_W'(1);

  ram_state_e            state_q, state_d;
  logic [RAM_WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_BUS_W-1:0] addr_q, addr_d;
  logic [MEM_SEL_W-1:0]  strb_q, strb_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  range_err_q, range_err_d;
  logic                  zero_q, zero_d;

  logic                  commit;
  logic [ADDR_BUS_W-1:0] c_addr;
  logic [MEM_SEL_W-1:0]  c_strb;
  logic [DATA_W-1:0]     c_wdata;
  logic                  c_oor;
  logic                  c_read;
  logic [MEM_SEL_W-1:0]  ram_we;
  logic                  ram_rd_en;
  logic [DATA_W-1:0]     ram_rdata;

  // With zero wait states the commit uses the live request instead of the latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    range_err_d = 1'b0;
    zero_d      = zero_q;
    commit      = 1'b0;
    c_addr      = addr_q;
    c_strb      = strb_q;
    c_wdata     = wdata_q;

    case (state_q)
      RAM_ST_IDLE: begin
        if (bus.ram_en) begin
          addr_d  = bus.ram_addr;
          strb_d  = bus.ram_write_en;
          wdata_d = bus.ram_write_data;
          cnt_d   = WAIT_INIT;
          c_addr  = bus.ram_addr;
          c_strb  = bus.ram_write_en;
          c_wdata = bus.ram_write_data;
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = RAM_ST_DONE;
          end else begin
            state_d = RAM_ST_BUSY;
          end
        end
      end
      RAM_ST_BUSY: begin
        cnt_d = cnt_q - WAIT_ONE;
        if (cnt_q == WAIT_ONE) begin
          commit  = 1'b1;
          state_d = RAM_ST_DONE;
        end
      end
      RAM_ST_DONE: state_d = RAM_ST_IDLE;
      default:     state_d = RAM_ST_IDLE;
    endcase

    c_oor  = addr_out_of_range(c_addr, ADDR_WIDTH);
    c_read = (c_strb == '0);

    if (commit) begin
      ready_d     = 1'b1;
      range_err_d = c_oor;
      if (c_read) zero_d = c_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RAM_ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      strb_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      range_err_q <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      range_err_q <= range_err_d;
      zero_q      <= zero_d;
    end
  end

  // Reset on the commit edge must abort the access, so the RAM strobes are gated by rst.
  assign ram_we    = (commit && !c_oor && !rst) ? c_strb : '0;
  assign ram_rd_en = commit && c_read && !c_oor && !rst;

  byte_lane_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .addr  (c_addr[ADDR_WIDTH+1:2]),
    .we    (ram_we),
    .wdata (c_wdata),
    .rd_en (ram_rd_en),
    .rdata (ram_rdata)
  );

  assign bus.ram_read_data = zero_q ? '0 : ram_rdata;
  assign bus.ram_ready     = ready_q;
  assign bus.ram_range_err = range_err_q;
  assign bus.stall_req     = ((state_q == RAM_ST_IDLE) && bus.ram_en) || (state_q == RAM_ST_BUSY);

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed plus randomized bench for data_ram_responder: one instance with 0 wait states, one with 2.
module tb_data_ram_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_ram_if bus0 ();
  data_ram_if bus2 ();

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  typedef struct packed {
    logic        stall;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
  } obs_t;

  int checks = 0;
  int errors = 0;

  // Reference: RAM image per instance and the read result each one should be holding.
  logic [31:0] model [2][1024];
  logic [31:0] exp_rd [2];

  function automatic obs_t sample(input bit s);
    obs_t o;
    if (s) begin
      o.stall = bus2.stall_req;
      o.ready = bus2.ram_ready;
      o.err   = bus2.ram_range_err;
      o.rdata = bus2.ram_read_data;
    end else begin
      o.stall = bus0.stall_req;
      o.ready = bus0.ram_ready;
      o.err   = bus0.ram_range_err;
      o.rdata = bus0.ram_read_data;
    end
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic driveReq(input bit s, input logic en, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] d);
    if (s) begin
      bus2.ram_en = en; bus2.ram_write_en = we; bus2.ram_addr = a; bus2.ram_write_data = d;
    end else begin
      bus0.ram_en = en; bus0.ram_write_en = we; bus0.ram_addr = a; bus0.ram_write_data = d;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      driveReq(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      driveReq(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  // One complete access: request cycle, wait for ready, then compare DONE-cycle outputs.
  task automatic applyStimulus(input bit s, input logic [3:0] strb,
                               input logic [31:0] addr, input logic [31:0] data);
    int          ws;
    int          cyc;
    bit          done;
    bit          oor;
    bit          wr;
    logic [9:0]  w;
    obs_t        o;
    ws   = s ? 2 : 0;
    oor  = (addr[31:12] != 20'h0);
    wr   = (strb != 4'h0);
    w    = addr[11:2];
    @(negedge clk);
    driveReq(s, 1'b1, strb, addr, data);
    #1;
    o = sample(s);
    checkOutput("req_stall", o.stall, 1);
    checkOutput("req_ready", o.ready, 0);
    cyc  = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (s) driveReq(s, 1'b1, 4'($urandom), $urandom, $urandom);
      #1;
      cyc++;
      o = sample(s);
      if (o.ready) done = 1;
      else checkOutput("busy_stall", o.stall, 1);
    end
    checkOutput("latency", cyc, 1 + ws);
    if (!oor) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) model[s][w][8*i +: 8] = data[8*i +: 8];
      end else begin
        exp_rd[s] = model[s][w];
      end
    end else if (!wr) begin
      exp_rd[s] = 32'h0;
    end
    checkOutput("done_stall", o.stall, 0);
    checkOutput("range_err", o.err, oor);
    checkOutput("rdata", o.rdata, exp_rd[s]);
  endtask

  initial begin
    obs_t        o;
    logic [31:0] a;
    logic [3:0]  st;
    int          idx;

    rst = 1'b1;
    driveReq(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    driveReq(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;

    // Reset and idle outputs on both instances.
    idleCycles(1);
    #1;
    for (int s = 0; s < 2; s++) begin
      o = sample(s[0]);
      checkOutput("rst_stall", o.stall, 0);
      checkOutput("rst_ready", o.ready, 0);
      checkOutput("rst_err", o.err, 0);
      checkOutput("rst_rdata", o.rdata, 32'h0);
    end

    // Give every word used later a known full-word value.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i <= 17; i++) begin
        a = (i == 17) ? 32'h0000_0FFC : 32'(i * 4);
        applyStimulus(s[0], 4'hF, a, $urandom);
      end
      idleCycles(1);
    end

    // Word write then read back, then byte-lane overwrite.
    applyStimulus(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    applyStimulus(1'b1, 4'h0, 32'h40, 32'h0);
    checkOutput("word_rd", bus2.ram_read_data, 32'hDEADBEEF);
    applyStimulus(1'b1, 4'b0100, 32'h40, 32'h00AA0000);
    checkOutput("hold_after_wr", bus2.ram_read_data, 32'hDEADBEEF);
    applyStimulus(1'b1, 4'h0, 32'h40, 32'h0);
    checkOutput("byte_rd", bus2.ram_read_data, 32'hDEAABEEF);
    idleCycles(1);

    // Zero wait states: back-to-back reads give stall 1,0,1,0.
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h4, 32'h0);
    idleCycles(1);

    // Out of range write is dropped (no alias onto word 0), read returns 0.
    applyStimulus(1'b1, 4'hF, 32'h0000_1000, 32'h5555_AAAA);
    applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h0000_1000, 32'h0);
    checkOutput("oor_rd_zero", bus2.ram_read_data, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h0000_0FFC, 32'h0);
    idleCycles(1);

    // Reset on the commit edge of a write aborts it.
    applyStimulus(1'b1, 4'hF, 32'h8, 32'hCAFEF00D);
    @(negedge clk);
    driveReq(1'b1, 1'b1, 4'hF, 32'h8, 32'h12345678);
    driveReq(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("abort_req_stall", bus2.stall_req, 1);
    @(negedge clk);
    #1;
    checkOutput("abort_busy_stall", bus2.stall_req, 1);
    @(negedge clk);
    rst = 1'b1;
    driveReq(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    #1;
    checkOutput("abort_stall", bus2.stall_req, 0);
    checkOutput("abort_ready", bus2.ram_ready, 0);
    checkOutput("abort_rdata", bus2.ram_read_data, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h8, 32'h0);
    checkOutput("abort_kept", bus2.ram_read_data, 32'hCAFEF00D);
    idleCycles(1);

    // Randomized mix of reads, lane writes and out-of-range accesses.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 60; n++) begin
        idx = $urandom_range(0, 17);
        a   = (idx == 17) ? 32'h0000_0FFC : 32'(idx * 4);
        if ($urandom_range(0, 7) == 0)
          a = {12'($urandom_range(1, 4095)), 8'h0, 10'($urandom), 2'b00};
        st = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        applyStimulus(s[0], st, a, $urandom);
        if ($urandom_range(0, 3) == 0) idleCycles(1);
      end
      idleCycles(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
